// File: rtl/tt_host_pkg.sv
// Shared constants and state encoding for the host pin-side bus responder.
package tt_host_pkg;

  localparam logic [7:0]  CMD_WRITE   = 8'h57;
  localparam logic [7:0]  CMD_READ    = 8'h52;
  localparam logic [31:0] RD_ERR_FILL = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    BUS,
    RDATA
  } state_e;

endpackage

// File: rtl/tt_host_bus_responder_sync.sv
// Synchronizes the asynchronous host toggle strobe and emits a one-cycle pulse per toggle.
module toggle_sync_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic stb_i,
  output logic evt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], stb_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt_o = sync_q[SYNC_STAGES-1] ^ last_q;

endmodule

// File: rtl/tt_host_bus_responder.sv
// Decodes host byte commands into single 32-bit core bus transfers; read data
// is returned byte-serially, one byte per host strobe toggle.
module tt_host_bus_responder
  import tt_host_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        host_din_i,
  input  logic              host_stb_i,
  output logic [7:0]        host_dout_o,
  output logic              host_busy_o,
  output logic              host_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_ready_i
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [1:0]          n_q, n_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                evt;

  toggle_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .stb_i (host_stb_i),
    .evt_o (evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      n_q     <= 2'd0;
      tmo_q   <= 8'd0;
      rdata_q <= 32'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      n_q     <= n_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    n_d     = n_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (evt) begin
          if (host_din_i == CMD_WRITE || host_din_i == CMD_READ) begin
            state_d = ADDR;
            is_wr_d = (host_din_i == CMD_WRITE);
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (evt) begin
          addr_d  = host_din_i[ADDR_W-1:0];
          n_d     = 2'd0;
          tmo_d   = 8'd0;
          state_d = is_wr_q ? WDATA : BUS;
        end
      end
      WDATA: begin
        if (evt) begin
          wdata_d[{n_q, 3'b000} +: 8] = host_din_i;
          n_d = n_q + 2'd1;
          if (n_q == 2'd3) begin
            state_d = BUS;
            tmo_d   = 8'd0;
          end
        end
      end
      BUS: begin
        // Host strobes seen here are intentionally discarded.
        if (bus_ready_i) begin
          n_d     = 2'd0;
          state_d = is_wr_q ? IDLE : RDATA;
          if (!is_wr_q) rdata_d = bus_rdata_i;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          n_d     = 2'd0;
          state_d = is_wr_q ? IDLE : RDATA;
          rdata_d = RD_ERR_FILL;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RDATA: begin
        if (evt) begin
          if (n_q == 2'd3) state_d = IDLE;
          else             n_d = n_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_req_o   = (state_q == BUS);
  assign bus_we_o    = (state_q == BUS) && is_wr_q;
  assign host_busy_o = (state_q == BUS);
  assign host_err_o  = err_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign host_dout_o = (state_q == RDATA) ? rdata_q[{n_q, 3'b000} +: 8] : 8'h00;

endmodule
